// File: rtl/aes_pkg.sv
// Shared AES definitions used by the encryption sequencer: the FSM state
// encoding, the round counts for each key size and the block width.
package aes_pkg;

   localparam int AES_BLK_W = 128;

   localparam int NR_AES128 = 10;
   localparam int NR_AES192 = 12;
   localparam int NR_AES256 = 14;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WHITEN  = 3'd1,
      PRESENT = 3'd2,
      CAPTURE = 3'd3,
      DONE    = 3'd4
   } seq_state_t;

endpackage

// File: rtl/aes_enc_seq.sv
// Iterative AES encryption sequencer.
// Accepts a plaintext block, whitens it with round key 0, then alternates
// PRESENT (datapath registers SubBytes, key RAM fetches key r) and CAPTURE
// (datapath result loaded into the state register) for NR rounds. The
// ciphertext is then held in DONE until the consumer takes it.
// Optional build macro AES_ENC_SEQ_BACK2BACK_EN: lets a new block be accepted
// in the same cycle as the ciphertext handshake, saving the IDLE cycle.
module aes_enc_seq
   import aes_pkg::*;
#(
   parameter int NR    = NR_AES128,
   parameter int RKA_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic [RKA_W-1:0]     rk_addr,
   input  logic [AES_BLK_W-1:0] rk_data,
   output logic [AES_BLK_W-1:0] dp_din,
   output logic [AES_BLK_W-1:0] dp_rkey,
   output logic                 dp_last,
   input  logic [AES_BLK_W-1:0] dp_dout,
   output logic                 busy
);

   // Round counter runs 1..NR; it doubles as the key RAM address in rounds.
   localparam logic [RKA_W-1:0] R_FIRST = RKA_W'(1);
   localparam logic [RKA_W-1:0] R_LAST  = RKA_W'(NR);

   seq_state_t           state_reg, state_next;
   logic [AES_BLK_W-1:0] st_reg, st_next;
   logic [RKA_W-1:0]     r_reg, r_next;
   logic                 in_round;

   // State, cipher state and round counter registers; reset abandons any block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         st_reg    <= '0;
         r_reg     <= '0;
      end else begin
         state_reg <= state_next;
         st_reg    <= st_next;
         r_reg     <= r_next;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_next = state_reg;
      st_next    = st_reg;
      r_next     = r_reg;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               st_next    = in_data;
               state_next = WHITEN;
            end
         end
         WHITEN: begin
            // rk_data holds key 0, fetched while the block was being accepted.
            st_next    = st_reg ^ rk_data;
            r_next     = R_FIRST;
            state_next = PRESENT;
         end
         PRESENT: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            st_next = dp_dout;
            if (r_reg == R_LAST) begin
               state_next = DONE;
            end else begin
               r_next     = r_reg + R_FIRST;
               state_next = PRESENT;
            end
         end
         DONE: begin
            out_valid = 1'b1;
`ifdef AES_ENC_SEQ_BACK2BACK_EN
            in_ready = out_ready;
            if (out_ready) begin
               if (in_valid) begin
                  st_next    = in_data;
                  state_next = WHITEN;
               end else begin
                  state_next = IDLE;
               end
            end
`else
            if (out_ready) begin
               state_next = IDLE;
            end
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // Never advertise readiness while reset is being applied.
      if (rst) begin
         in_ready = 1'b0;
      end
   end

   // Key address is the round number during rounds and key 0 otherwise, so
   // key 0 is always ready for the whitening step after an accept.
   assign in_round = (state_reg == PRESENT) || (state_reg == CAPTURE);
   assign rk_addr  = in_round ? r_reg : '0;
   assign dp_last  = in_round && (r_reg == R_LAST);

   assign dp_din   = st_reg;
   assign dp_rkey  = rk_data;
   assign out_data = st_reg;
   assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_aes_enc_seq.sv
// Testbench for aes_enc_seq: two instances (AES-128, NR=10 and AES-256,
// NR=14), each with a key RAM and round datapath built from a local AES model.
// Build macro AES_ENC_SEQ_BACK2BACK_EN selects the expected block spacing.
`timescale 1ns/1ps
module tb_aes_enc_seq;
   import aes_pkg::*;

   localparam int RKA_W = 4;
   localparam int NR_A  = NR_AES128;
   localparam int NR_B  = NR_AES256;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_ENC_SEQ_BACK2BACK_EN
   localparam int B2B_GAP = 2*NR_A + 2;
`else
   localparam int B2B_GAP = 2*NR_A + 3;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   // ---------------- AES model ----------------
   logic [7:0]   sbox  [0:255];
   logic [127:0] ram_a [0:15];
   logic [127:0] ram_b [0:15];

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = xtime(x);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s);
      logic [127:0] o;
      for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox[s[8*i +: 8]];
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8]; a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8]; a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   function automatic logic [127:0] ref_encrypt_a(input logic [127:0] pt);
      logic [127:0] s;
      s = pt ^ ram_a[0];
      for (int r = 1; r <= NR_A; r++) begin
         s = shift_rows(sub_bytes(s));
         if (r != NR_A) s = mix_columns(s);
         s = s ^ ram_a[r];
      end
      return s;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                   ^ {b[3:0], b[7:4]} ^ 8'h63;
      end
   endtask

   task automatic expand_key(input logic [255:0] key, input int nk, input int nr,
                             input bit to_b);
      logic [31:0] w [0:59];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = xtime(rc);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int k = 0; k <= nr; k++) begin
         if (to_b) ram_b[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
         else      ram_a[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
      end
   endtask

   // ---------------- DUT A: AES-128 ----------------
   logic             in_valid, in_ready, out_valid, out_ready, dp_last, busy;
   logic [127:0]     in_data, out_data, rk_data, dp_din, dp_rkey, dp_dout, sb_a;
   logic [RKA_W-1:0] rk_addr;

   aes_enc_seq #(.NR(NR_A), .RKA_W(RKA_W)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rk_addr(rk_addr), .rk_data(rk_data),
      .dp_din(dp_din), .dp_rkey(dp_rkey), .dp_last(dp_last), .dp_dout(dp_dout),
      .busy(busy)
   );

   always @(posedge clk) begin
      sb_a    <= sub_bytes(dp_din);
      rk_data <= ram_a[rk_addr];
   end
   assign dp_dout = dp_last ? (shift_rows(sb_a) ^ dp_rkey)
                            : (mix_columns(shift_rows(sb_a)) ^ dp_rkey);

   // ---------------- DUT B: AES-256 ----------------
   logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_dp_last, b_busy;
   logic [127:0]     b_in_data, b_out_data, b_rk_data, b_dp_din, b_dp_rkey, b_dp_dout, sb_b;
   logic [RKA_W-1:0] b_rk_addr;

   aes_enc_seq #(.NR(NR_B), .RKA_W(RKA_W)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .rk_addr(b_rk_addr), .rk_data(b_rk_data),
      .dp_din(b_dp_din), .dp_rkey(b_dp_rkey), .dp_last(b_dp_last), .dp_dout(b_dp_dout),
      .busy(b_busy)
   );

   always @(posedge clk) begin
      sb_b      <= sub_bytes(b_dp_din);
      b_rk_data <= ram_b[b_rk_addr];
   end
   assign b_dp_dout = b_dp_last ? (shift_rows(sb_b) ^ b_dp_rkey)
                                : (mix_columns(shift_rows(sb_b)) ^ b_dp_rkey);

   // ---------------- scoreboards ----------------
   logic [127:0] exp_q   [$];
   logic [127:0] exp_q_b [$];

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      b_in_valid = 1'b0; b_out_ready = 1'b1; b_in_data = '0;
      repeat (3) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (rk_addr !== '0) begin errors++; $display("FAIL reset_rk_addr: got %0d want 0", rk_addr); end
      checks++; if (dp_last !== 1'b0) begin errors++; $display("FAIL reset_dp_last: got %b want 0", dp_last); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
      checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready); end
      @(negedge clk);
   endtask

   task automatic test_fips128();
      int n, acc_cyc, lat, last_cnt, last_bad, busy_low;
      int addr_seq [$];
      logic got;
      logic [127:0] exp;
      last_cnt = 0; last_bad = 0; busy_low = 0; lat = -1; got = 1'b0;
      out_ready = 1'b1; in_data = PT_C; in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL fips128_accept: in_ready=%b want 1 within 20 cycles", in_ready);
         in_valid = 1'b0; return;
      end
      exp_q.push_back(CT_128);
      acc_cyc = cyc;
      addr_seq.push_back(int'(rk_addr));
      $display("tx accept A pt=%h", PT_C);
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (out_valid === 1'b1) begin got = 1'b1; lat = cyc - acc_cyc - 1; break; end
         if (busy !== 1'b1) busy_low++;
         if (dp_last === 1'b1) begin
            last_cnt++;
            if (rk_addr != RKA_W'(NR_A)) last_bad++;
         end
         if (addr_seq[$] != int'(rk_addr)) addr_seq.push_back(int'(rk_addr));
         @(negedge clk);
      end
      checks++; if (!got) begin errors++; $display("FAIL fips128_out_valid: none within 60 cycles, want one"); return; end
      checks++; if (lat != 2*NR_A+1) begin errors++; $display("FAIL fips128_latency: got %0d want %0d", lat, 2*NR_A+1); end
      checks++; if (busy_low != 0) begin errors++; $display("FAIL fips128_busy: low in %0d round cycles want 0", busy_low); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fips128_busy_done: got %b want 1", busy); end
      checks++; if (last_cnt != 2) begin errors++; $display("FAIL fips128_dp_last_count: got %0d want 2", last_cnt); end
      checks++; if (last_bad != 0) begin errors++; $display("FAIL fips128_dp_last_round: high outside round %0d in %0d cycles want 0", NR_A, last_bad); end
      checks++;
      if (addr_seq.size() != NR_A+1) begin
         errors++; $display("FAIL fips128_rk_addr_len: got %0d distinct addrs want %0d", addr_seq.size(), NR_A+1);
      end else begin
         for (int i = 0; i <= NR_A; i++) begin
            checks++;
            if (addr_seq[i] != i) begin errors++; $display("FAIL fips128_rk_addr_seq[%0d]: got %0d want %0d", i, addr_seq[i], i); end
         end
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL fips128_out_data: unexpected output %h, want no output", out_data);
      end else begin
         exp = exp_q.pop_front();
         if (out_data !== exp) begin errors++; $display("FAIL fips128_out_data: got %h want %h", out_data, exp); end
      end
      $display("tx output A ct=%h", out_data);
      @(negedge clk);
      checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fips128_after_handshake: busy=%b out_valid=%b want 0 0", busy, out_valid); end
   endtask

   task automatic test_backpressure();
      int n, beats;
      logic [127:0] pt, held, exp;
      pt = {$urandom(), $urandom(), $urandom(), $urandom()};
      out_ready = 1'b0; in_data = pt; in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept: in_ready=%b want 1", in_ready); in_valid = 1'b0; return; end
      exp_q.push_back(ref_encrypt_a(pt));
      $display("tx accept A pt=%h", pt);
      @(negedge clk);
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 60) begin @(negedge clk); n++; end
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b want 1 within 60 cycles", out_valid); return; end
      held = out_data;
      in_data = ~pt; in_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
         checks++; if (out_data !== held) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h want %h", i, out_data, held); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
         @(negedge clk);
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (exp_q.size() == 0) begin
         errors++; $display("FAIL bp_out_data: unexpected output %h, want no output", out_data);
      end else begin
         exp = exp_q.pop_front();
         if (out_data !== exp) begin errors++; $display("FAIL bp_out_data: got %h want %h", out_data, exp); end
      end
      $display("tx output A ct=%h", out_data);
      @(negedge clk);
      beats = 0;
      for (int i = 0; i < 5; i++) begin
         if (out_valid === 1'b1) beats++;
         @(negedge clk);
      end
      checks++; if (beats != 0) begin errors++; $display("FAIL bp_single_beat: extra beats %0d want 0", beats); end
   endtask

   task automatic test_reset_mid();
      int n, acc_cyc, spurious;
      out_ready = 1'b1; in_data = PT_C; in_valid = 1'b1;
      n = 0;
      while (in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept: in_ready=%b want 1", in_ready); in_valid = 1'b0; return; end
      exp_q.push_back(CT_128);
      acc_cyc = cyc;
      $display("tx accept A pt=%h", PT_C);
      @(negedge clk);
      in_valid = 1'b0;
      while (cyc - acc_cyc < 10) @(negedge clk);
      checks++; if (rk_addr !== RKA_W'(5)) begin errors++; $display("FAIL rmid_round: rk_addr=%0d want 5", rk_addr); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b want 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready: got %b want 1", in_ready); end
      spurious = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid === 1'b1) spurious++;
      end
      checks++; if (spurious != 0) begin errors++; $display("FAIL rmid_no_output: %0d output cycles want 0", spurious); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] pts [2];
      logic [127:0] exp;
      int nacc, nout, nrise;
      int rise [2];
      logic prev_ov;
      pts[0] = PT_C;
      pts[1] = {$urandom(), $urandom(), $urandom(), $urandom()};
      nacc = 0; nout = 0; nrise = 0; prev_ov = 1'b0;
      rise[0] = 0; rise[1] = 0;
      out_ready = 1'b1; in_data = pts[0]; in_valid = 1'b1;
      for (int k = 0; k < 120 && nout < 2; k++) begin
         if (out_valid === 1'b1 && !prev_ov) begin
            if (nrise < 2) rise[nrise] = cyc;
            nrise++;
         end
         prev_ov = out_valid;
         if (out_valid === 1'b1 && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_out_data[%0d]: unexpected output %h, want no output", nout, out_data);
            end else begin
               exp = exp_q.pop_front();
               if (out_data !== exp) begin errors++; $display("FAIL b2b_out_data[%0d]: got %h want %h", nout, out_data, exp); end
            end
            $display("tx output A ct=%h", out_data);
            nout++;
         end
         if (in_valid && in_ready === 1'b1) begin
            exp_q.push_back(nacc == 0 ? CT_128 : ref_encrypt_a(pts[1]));
            $display("tx accept A pt=%h", in_data);
            nacc++;
         end
         @(negedge clk);
         if (nacc == 1) in_data = pts[1];
         if (nacc >= 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++; if (nout != 2) begin errors++; $display("FAIL b2b_count: got %0d outputs want 2", nout); end
      checks++; if (nrise < 2 || rise[1] - rise[0] != B2B_GAP) begin errors++; $display("FAIL b2b_spacing: got %0d cycles want %0d", rise[1] - rise[0], B2B_GAP); end
      @(negedge clk);
   endtask

   task automatic test_aes256();
      int n, acc_cyc, lat;
      logic [127:0] exp;
      b_out_ready = 1'b1; b_in_data = PT_C; b_in_valid = 1'b1;
      n = 0;
      while (b_in_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (b_in_ready !== 1'b1) begin errors++; $display("FAIL aes256_accept: in_ready=%b want 1", b_in_ready); b_in_valid = 1'b0; return; end
      exp_q_b.push_back(CT_256);
      acc_cyc = cyc;
      $display("tx accept B pt=%h", PT_C);
      @(negedge clk);
      b_in_valid = 1'b0;
      n = 0;
      while (b_out_valid !== 1'b1 && n < 80) begin @(negedge clk); n++; end
      checks++;
      if (b_out_valid !== 1'b1) begin errors++; $display("FAIL aes256_out_valid: got %b want 1 within 80 cycles", b_out_valid); return; end
      lat = cyc - acc_cyc - 1;
      checks++; if (lat != 2*NR_B+1) begin errors++; $display("FAIL aes256_latency: got %0d want %0d", lat, 2*NR_B+1); end
      checks++;
      if (exp_q_b.size() == 0) begin
         errors++; $display("FAIL aes256_out_data: unexpected output %h, want no output", b_out_data);
      end else begin
         exp = exp_q_b.pop_front();
         if (b_out_data !== exp) begin errors++; $display("FAIL aes256_out_data: got %h want %h", b_out_data, exp); end
      end
      $display("tx output B ct=%h", b_out_data);
      @(negedge clk);
      checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL aes256_after_handshake: out_valid=%b want 0", b_out_valid); end
   endtask

   initial begin
      build_sbox();
      for (int k = 0; k < 16; k++) begin ram_a[k] = '0; ram_b[k] = '0; end
      expand_key({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4, NR_A, 1'b0);
      expand_key(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, NR_B, 1'b1);
      test_reset();
      test_fips128();
      test_backpressure();
      test_reset_mid();
      test_fips128();
      test_back_to_back();
      test_aes256();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time %0t reached, want finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
